trng_key_collector: RTL and testbench

//   Consumer stage directly downstream of the TRNG output FIFO. On request it pulls
//   KEY_BYTES random bytes through the read_req/data_ready interface, runs a

---
 rtl/trng_key_collector_if.sv | 29 ++
 rtl/trng_key_collector.sv | 120 ++++++++++++
 tb/tb_trng_key_collector.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_key_collector_if.sv
// Purpose: bundles the TRNG FIFO read port and the key valid/ack port of the key collector.
// Latency: none, wires only.
// Backpressure: trng_ready throttles reads; key_ack releases a presented key.
`timescale 1ns/1ps
interface trng_key_collector_if #(
    parameter int KEY_W = 64
);
    logic             start;
    logic             trng_ready;
    logic             trng_rd;
    logic [7:0]       trng_byte;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_ack;
    logic             busy;
    logic             health_fail;

    // Requester side: owns the FIFO data and the key consumer.
    modport master (
        output start, trng_ready, trng_byte, key_ack,
        input  trng_rd, key_out, key_valid, busy, health_fail
    );

    // Collector side.
    modport slave (
        input  start, trng_ready, trng_byte, key_ack,
        output trng_rd, key_out, key_valid, busy, health_fail
    );
endinterface

// File: rtl/trng_key_collector.sv
// Purpose: pulls KEY_BYTES bytes from the TRNG FIFO, repetition-count tests them, presents one key.
// Latency: 2 cycles per byte with trng_ready high; key_valid 2*KEY_BYTES+1 edges after start.
// Backpressure: no read while trng_ready is low; a key is held until key_ack while key_valid.
`timescale 1ns/1ps
module trng_key_collector #(
    parameter int KEY_BYTES = 8,
    parameter int REP_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    trng_key_collector_if.slave   bus
);
    localparam int KEY_W = 8 * KEY_BYTES;
    localparam int CNT_W = $clog2(KEY_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [KEY_W-1:0]   shift_q;
    logic [7:0]         run_len;
    logic [7:0]         next_run;
    logic               key_valid_q;
    logic [KEY_W-1:0]   key_out_q;
    logic               busy_q;
    logic               health_fail_q;

    // Read strobe decoded from registered state so an async reset kills it at once.
    assign bus.trng_rd     = (state == ST_FETCH) && bus.trng_ready;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_out     = key_out_q;
    assign bus.busy        = busy_q;
    assign bus.health_fail = health_fail_q;

    // Run length after the byte on trng_byte; a zero run marks the first byte of a key.
    always_comb begin
        next_run = 8'd1;
        if (run_len != 8'd0 && bus.trng_byte == shift_q[7:0]) begin
            next_run = run_len + 8'd1;
        end
    end

    // Main FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            byte_cnt      <= '0;
            shift_q       <= '0;
            run_len       <= '0;
            key_valid_q   <= 1'b0;
            key_out_q     <= '0;
            busy_q        <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            health_fail_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_FETCH;
                        busy_q   <= 1'b1;
                        byte_cnt <= '0;
                        shift_q  <= '0;
                        run_len  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.trng_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (next_run == 8'(REP_LIMIT)) begin
                        // Health failure wins over completion: drop the partial key and retry.
                        health_fail_q <= 1'b1;
                        byte_cnt      <= '0;
                        shift_q       <= '0;
                        run_len       <= '0;
                        state         <= ST_FETCH;
                    end else begin
                        shift_q <= {shift_q[KEY_W-9:0], bus.trng_byte};
                        run_len <= next_run;
                        if (byte_cnt == CNT_W'(KEY_BYTES - 1)) begin
                            state <= ST_PRESENT;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (key_valid_q && bus.key_ack) begin
                        key_valid_q <= 1'b0;
                        key_out_q   <= '0;
                        byte_cnt    <= '0;
                        shift_q     <= '0;
                        run_len     <= '0;
                        if (bus.start) begin
                            state <= ST_FETCH;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        key_valid_q <= 1'b1;
                        key_out_q   <= shift_q;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trng_key_collector.sv
// Purpose: self-checking bench for trng_key_collector with a FIFO model and key scoreboard.
// Latency: checks key_valid timing with and without trng_ready stalls.
// Backpressure: exercises trng_ready stalls, held keys and back-to-back start with key_ack.
`timescale 1ns/1ps
module tb_trng_key_collector;
    localparam int KB = 8;
    localparam int RL = 4;
    localparam int KW = 8 * KB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    trng_key_collector_if #(.KEY_W(KW)) bus();

    trng_key_collector #(.KEY_BYTES(KB), .REP_LIMIT(RL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]    fifo_q[$];
    logic [KW-1:0] exp_q[$];
    logic          rd_pending = 1'b0;
    int            rd_cnt = 0;
    int            stall_at = -1;
    int            stall_len = 0;
    int            stall_left = 0;
    int            ready_pct = 100;
    int            hf_cnt = 0;
    int            exp_hf = 0;

    // Reference model state: bytes of the key in progress and the current run.
    logic [7:0]    m_bytes[$];
    int            m_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Model: append a byte to the FIFO and to the key being built by the rules.
    task automatic model_feed(input logic [7:0] b, output bit done);
        logic [KW-1:0] key;
        done = 1'b0;
        fifo_q.push_back(b);
        if (m_bytes.size() > 0 && b == m_bytes[m_bytes.size()-1]) m_run++;
        else m_run = 1;
        m_bytes.push_back(b);
        if (m_run == RL) begin
            exp_hf++;
            m_bytes.delete();
            m_run = 0;
        end else if (m_bytes.size() == KB) begin
            key = '0;
            for (int i = 0; i < KB; i++) key[KW-1-8*i -: 8] = m_bytes[i];
            exp_q.push_back(key);
            m_bytes.delete();
            m_run = 0;
            done = 1'b1;
        end
    endtask

    task automatic feed_seq(input logic [7:0] first, input int count);
        bit d;
        for (int i = 0; i < count; i++) model_feed(first + 8'(i), d);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_key(input int max_cyc, output int n);
        n = 0;
        while (!bus.key_valid && n < max_cyc) begin
            tick();
            n++;
        end
        if (!bus.key_valid) check("key_valid_timeout", 64'(bus.key_valid), 64'd1);
    endtask

    task automatic wait_reads(input int target);
        int n = 0;
        while (rd_cnt < target && n < 500) begin
            tick();
            n++;
        end
        if (rd_cnt < target) check("read_timeout", 64'(rd_cnt), 64'(target));
    endtask

    task automatic ack_key();
        bus.key_ack = 1'b1;
        tick();
        bus.key_ack = 1'b0;
        check("ack_valid_low", 64'(bus.key_valid), 64'd0);
        check("ack_busy_low", 64'(bus.busy), 64'd0);
    endtask

    // TRNG FIFO model: data appears on trng_byte in the cycle after a read strobe.
    initial begin
        bus.trng_ready = 1'b0;
        bus.trng_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_pending) begin
                if (fifo_q.size() > 0) bus.trng_byte = fifo_q.pop_front();
                rd_pending = 1'b0;
            end
            if (stall_left > 0) stall_left--;
            bus.trng_ready = (fifo_q.size() > 0) && (stall_left == 0) &&
                             ($urandom_range(99) < ready_pct);
            #1;
            if (bus.trng_rd === 1'b1) begin
                rd_pending = 1'b1;
                rd_cnt++;
                if (rd_cnt == stall_at) stall_left = stall_len + 2;
            end
        end
    end

    // Monitor: scoreboard pop on each new key plus per-cycle protocol checks.
    initial begin
        logic kv_prev = 1'b0;
        logic rd_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n) begin
                if (bus.key_valid && !kv_prev) begin
                    if (exp_q.size() == 0) check("key_unexpected", bus.key_out, 64'd0 - 64'd1);
                    else check("key_value", bus.key_out, exp_q.pop_front());
                end
                if (!bus.key_valid) check("key_out_zero", bus.key_out, 64'd0);
                if (bus.trng_rd) begin
                    check("rd_needs_ready", 64'(bus.trng_ready), 64'd1);
                    check("rd_one_outstanding", 64'(rd_prev), 64'd0);
                end
                if (bus.health_fail) hf_cnt++;
            end
            kv_prev = bus.key_valid;
            rd_prev = bus.trng_rd;
        end
    end

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int  n;
        int  base;
        bit  d;
        logic [7:0] b;
        logic [7:0] prev_b;

        bus.start   = 1'b0;
        bus.key_ack = 1'b0;
        tick();
        tick();
        check("rst_trng_rd", 64'(bus.trng_rd), 64'd0);
        check("rst_key_valid", 64'(bus.key_valid), 64'd0);
        check("rst_key_out", bus.key_out, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_health_fail", 64'(bus.health_fail), 64'd0);
        reset_n = 1'b1;
        tick();

        // Test 1: plain key, latency and read count.
        base = rd_cnt;
        feed_seq(8'h01, 8);
        do_start();
        check("t1_busy", 64'(bus.busy), 64'd1);
        wait_key(200, n);
        check("t1_latency", 64'(n), 64'd17);
        check("t1_reads", 64'(rd_cnt - base), 64'd8);
        check("t1_key", bus.key_out, 64'h0102030405060708);

        // Test 2: key held without ack.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t2_valid_held", 64'(bus.key_valid), 64'd1);
            check("t2_key_stable", bus.key_out, 64'h0102030405060708);
            check("t2_no_read", 64'(bus.trng_rd), 64'd0);
        end
        ack_key();

        // Test 3: five-cycle trng_ready stall after byte 3.
        base = rd_cnt;
        stall_at = base + 3;
        stall_len = 5;
        feed_seq(8'h01, 8);
        do_start();
        wait_key(200, n);
        check("t3_latency", 64'(n), 64'd22);
        check("t3_key", bus.key_out, 64'h0102030405060708);
        stall_at = -1;
        ack_key();

        // Test 4: repetition run triggers one retry.
        base = rd_cnt;
        n = exp_hf;
        for (int i = 0; i < 4; i++) model_feed(8'hAA, d);
        feed_seq(8'h11, 8);
        check("t4_model_hf", 64'(exp_hf - n), 64'd1);
        do_start();
        wait_reads(base + 4);
        tick();
        check("t4_hf_not_early", 64'(bus.health_fail), 64'd0);
        tick();
        check("t4_hf_pulse", 64'(bus.health_fail), 64'd1);
        tick();
        check("t4_hf_one_cycle", 64'(bus.health_fail), 64'd0);
        wait_key(200, n);
        check("t4_reads", 64'(rd_cnt - base), 64'd12);
        check("t4_key", bus.key_out, 64'h1112131415161718);
        ack_key();

        // Test 5: asynchronous reset during the WAIT of byte 5.
        base = rd_cnt;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h01 + 8'(i));
        do_start();
        wait_reads(base + 5);
        tick();
        reset_n = 1'b0;
        #1;
        check("t5_rst_trng_rd", 64'(bus.trng_rd), 64'd0);
        check("t5_rst_key_valid", 64'(bus.key_valid), 64'd0);
        check("t5_rst_key_out", bus.key_out, 64'd0);
        check("t5_rst_busy", 64'(bus.busy), 64'd0);
        check("t5_rst_health_fail", 64'(bus.health_fail), 64'd0);
        fifo_q.delete();
        rd_pending = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        feed_seq(8'h21, 8);
        do_start();
        wait_key(200, n);
        check("t5_key", bus.key_out, 64'h2122232425262728);

        // Test 6: start with ack chains keys; start alone is ignored.
        feed_seq(8'h31, 8);
        bus.start = 1'b1;
        bus.key_ack = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.key_ack = 1'b0;
        check("t6_b2b_valid_low", 64'(bus.key_valid), 64'd0);
        check("t6_b2b_busy", 64'(bus.busy), 64'd1);
        check("t6_b2b_read", 64'(bus.trng_rd), 64'd1);
        wait_key(200, n);
        check("t6_key", bus.key_out, 64'h3132333435363738);
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_start_ignored_valid", 64'(bus.key_valid), 64'd1);
            check("t6_start_ignored_rd", 64'(bus.trng_rd), 64'd0);
        end
        bus.start = 1'b0;
        ack_key();

        // Random keys with a repeat-heavy byte stream and random trng_ready.
        ready_pct = 70;
        prev_b = 8'h00;
        for (int k = 0; k < 20; k++) begin
            d = 1'b0;
            while (!d) begin
                if ($urandom_range(99) < 55) b = prev_b;
                else b = 8'($urandom_range(255));
                prev_b = b;
                model_feed(b, d);
            end
            do_start();
            wait_key(3000, n);
            for (int i = $urandom_range(3); i > 0; i--) tick();
            ack_key();
        end

        check("hf_total", 64'(hf_cnt), 64'(exp_hf));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
